// File: rtl/ps2_keyboard_if.sv
// ps2_keyboard_if: PS/2 pins in, Hack key code and status pulses out
interface ps2_keyboard_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] key;
    logic        key_strobe;
    logic        frame_err;
    modport master (output ps2_clk, ps2_data, input key, key_strobe, frame_err);
    modport slave (input ps2_clk, ps2_data, output key, key_strobe, frame_err);
endinterface

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 set-2 frame receiver with prefix handling and Hack key translation
module ps2_keyboard #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W = 17
) (
    input logic clk,
    input logic rst_n,
    ps2_keyboard_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_nx;
    logic [1:0] clk_sync, dat_sync;
    logic clk_prev, fe, d, par, ext, brk, frame_done, valid, bad, timeout, prefix, upd;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [CNT_W-1:0] cnt;
    logic [15:0] key, code;
    logic key_strobe, frame_err;
    assign fe = !clk_sync[1] && clk_prev;
    assign d = dat_sync[1];
    function automatic logic [15:0] xlate(input logic e, input logic [7:0] b);
        case ({e, b})
            9'h01C: return 16'd65;  9'h032: return 16'd66;  9'h021: return 16'd67;
            9'h023: return 16'd68;  9'h024: return 16'd69;  9'h02B: return 16'd70;
            9'h034: return 16'd71;  9'h033: return 16'd72;  9'h043: return 16'd73;
            9'h03B: return 16'd74;  9'h042: return 16'd75;  9'h04B: return 16'd76;
            9'h03A: return 16'd77;  9'h031: return 16'd78;  9'h044: return 16'd79;
            9'h04D: return 16'd80;  9'h015: return 16'd81;  9'h02D: return 16'd82;
            9'h01B: return 16'd83;  9'h02C: return 16'd84;  9'h03C: return 16'd85;
            9'h02A: return 16'd86;  9'h01D: return 16'd87;  9'h022: return 16'd88;
            9'h035: return 16'd89;  9'h01A: return 16'd90;
            9'h045: return 16'd48;  9'h016: return 16'd49;  9'h01E: return 16'd50;
            9'h026: return 16'd51;  9'h025: return 16'd52;  9'h02E: return 16'd53;
            9'h036: return 16'd54;  9'h03D: return 16'd55;  9'h03E: return 16'd56;
            9'h046: return 16'd57;
            9'h029: return 16'd32;  9'h05A: return 16'd128; 9'h066: return 16'd129;
            9'h076: return 16'd140;
            9'h005: return 16'd141; 9'h006: return 16'd142; 9'h004: return 16'd143;
            9'h00C: return 16'd144; 9'h003: return 16'd145; 9'h00B: return 16'd146;
            9'h083: return 16'd147; 9'h00A: return 16'd148; 9'h001: return 16'd149;
            9'h009: return 16'd150; 9'h078: return 16'd151; 9'h007: return 16'd152;
            9'h16B: return 16'd130; 9'h175: return 16'd131; 9'h174: return 16'd132;
            9'h172: return 16'd133; 9'h16C: return 16'd134; 9'h169: return 16'd135;
            9'h17D: return 16'd136; 9'h17A: return 16'd137; 9'h170: return 16'd138;
            9'h171: return 16'd139;
            default: return 16'd0;
        endcase
    endfunction
    // next state, frame completion and key decode
    always_comb begin
        state_nx = state;
        frame_done = 1'b0;
        timeout = state != IDLE && !fe && cnt == CNT_W'(TIMEOUT_CYCLES);
        if (timeout)
            state_nx = IDLE;
        else if (fe)
            case (state)
                IDLE: state_nx = d ? IDLE : DATA;
                DATA: state_nx = bit_cnt == 3'd7 ? PARITY : DATA;
                PARITY: state_nx = STOP;
                default: begin
                    state_nx = IDLE;
                    frame_done = 1'b1;
                end
            endcase
        valid = frame_done && d && ^{sr, par};
        bad = (frame_done && !valid) || timeout;
        prefix = sr == 8'hE0 || sr == 8'hF0;
        code = xlate(ext, sr);
        upd = valid && !prefix && code != 16'd0 && (brk ? code == key : code != key);
    end
    // FSM state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    // synchronisers, receive datapath, timeout counter and key register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '0;
            dat_sync <= '0;
            clk_prev <= 1'b0;
            sr <= '0;
            par <= 1'b0;
            bit_cnt <= '0;
            cnt <= '0;
            ext <= 1'b0;
            brk <= 1'b0;
            key <= '0;
            key_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], bus.ps2_clk};
            dat_sync <= {dat_sync[0], bus.ps2_data};
            clk_prev <= clk_sync[1];
            cnt <= (fe || timeout || state == IDLE) ? '0 : cnt + CNT_W'(1);
            if (fe && state == IDLE) bit_cnt <= '0;
            if (fe && state == DATA) begin
                sr <= {d, sr[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (fe && state == PARITY) par <= d;
            if (bad) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (valid) begin
                ext <= sr == 8'hE0 ? 1'b1 : sr == 8'hF0 ? ext : 1'b0;
                brk <= sr == 8'hF0 ? 1'b1 : sr == 8'hE0 ? brk : 1'b0;
            end
            key <= upd ? (brk ? 16'd0 : code) : key;
            key_strobe <= upd;
            frame_err <= bad;
        end
    end
    assign bus.key = key;
    assign bus.key_strobe = key_strobe;
    assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: randomized and directed PS/2 frames checked against a behavioural key model
module tb_ps2_keyboard;
    localparam int TO = 200;
    localparam logic [7:0] LET [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
        8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIG [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    localparam logic [7:0] FK [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
    localparam logic [7:0] EXT [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};
    localparam logic [7:0] POOL [24] = '{8'h1C, 8'h32, 8'h1B, 8'h1A, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66, 8'h76,
        8'h05, 8'h83, 8'h07, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'h75, 8'h6B, 8'h7D, 8'h71, 8'h12, 8'h14};
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic settling = 1'b1;
    int n_cmp = 0, n_bad = 0, n_strobe = 0, n_err = 0;
    logic [15:0] exp_key = 16'd0;
    bit m_ext = 1'b0, m_brk = 1'b0;
    ps2_keyboard_if bus();
    ps2_keyboard #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [15:0] hack_code(input bit e, input logic [7:0] b);
        if (e) begin
            for (int i = 0; i < 10; i++) if (b == EXT[i]) return 16'(130 + i);
            return 16'd0;
        end
        for (int i = 0; i < 26; i++) if (b == LET[i]) return 16'(65 + i);
        for (int i = 0; i < 10; i++) if (b == DIG[i]) return 16'(48 + i);
        for (int i = 0; i < 12; i++) if (b == FK[i]) return 16'(141 + i);
        if (b == 8'h29) return 16'd32;
        if (b == 8'h5A) return 16'd128;
        if (b == 8'h66) return 16'd129;
        if (b == 8'h76) return 16'd140;
        return 16'd0;
    endfunction
    task automatic model(input logic [7:0] b, input bit ok, output int es, output int ee);
        logic [15:0] c;
        es = 0;
        ee = 0;
        if (!ok) begin
            ee = 1;
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            c = hack_code(m_ext, b);
            if (!m_brk && c != 0 && c != exp_key) begin
                exp_key = c;
                es = 1;
            end else if (m_brk && c != 0 && c == exp_key) begin
                exp_key = 0;
                es = 1;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask
    task automatic ps2_bit(input logic v);
        @(negedge clk) bus.ps2_data = v;
        repeat (5) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (10) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int s0, e0, es, ee;
        settling = 1'b1;
        s0 = n_strobe;
        e0 = n_err;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_par);
        ps2_bit(!bad_stop);
        bus.ps2_data = 1'b1;
        model(b, !bad_par && !bad_stop, es, ee);
        repeat (3) @(negedge clk);
        settling = 1'b0;
        check("frame_strobes", 16'(n_strobe - s0), 16'(es));
        check("frame_errs", 16'(n_err - e0), 16'(ee));
    endtask
    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask
    always @(negedge clk)
        if (rst_n) begin
            if (bus.key_strobe) n_strobe++;
            if (bus.frame_err) n_err++;
            if (!settling) begin
                check("key_vs_model", bus.key, exp_key);
                check("strobe_quiet", 16'(bus.key_strobe), 16'd0);
                check("err_quiet", 16'(bus.frame_err), 16'd0);
            end
        end
    initial begin
        int s0, e0;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_key", bus.key, 16'd0);
        check("reset_strobe", 16'(bus.key_strobe), 16'd0);
        check("reset_err", 16'(bus.frame_err), 16'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        settling = 1'b0;
        send(8'h1C);
        check("press_A", bus.key, 16'd65);
        send(8'hF0); send(8'h1C);
        check("release_A", bus.key, 16'd0);
        send(8'hE0); send(8'h75);
        check("press_up", bus.key, 16'd131);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("release_up", bus.key, 16'd0);
        send(8'h75);
        check("plain_75_ignored", bus.key, 16'd0);
        send(8'h1C); send(8'h1B); send(8'hF0); send(8'h1C);
        check("stale_break", bus.key, 16'd83);
        s0 = n_strobe;
        send(8'h1C); send(8'h1C); send(8'h1C);
        check("typematic_one_strobe", 16'(n_strobe - s0), 16'd1);
        send_frame(8'h1C, 1'b1, 1'b0);
        check("bad_parity_keeps_key", bus.key, 16'd65);
        send(8'hF0); send(8'h1C);
        send(8'hF0);
        send_frame(8'h1C, 1'b1, 1'b0);
        send(8'h1C);
        check("brk_cleared_by_err", bus.key, 16'd65);
        send_frame(8'h29, 1'b0, 1'b1);
        check("bad_stop_keeps_key", bus.key, 16'd65);
        settling = 1'b1;
        s0 = n_strobe;
        e0 = n_err;
        send(8'hF0);
        settling = 1'b1;
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        bus.ps2_data = 1'b1;
        repeat (TO + 40) @(negedge clk);
        check("timeout_err", 16'(n_err - e0), 16'd1);
        m_ext = 0;
        m_brk = 0;
        settling = 1'b0;
        send(8'h29);
        check("after_timeout", bus.key, 16'd32);
        check("timeout_strobes", 16'(n_strobe - s0), 16'd1);
        send(8'h1C);
        settling = 1'b1;
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_key", bus.key, 16'd0);
        check("async_reset_strobe", 16'(bus.key_strobe), 16'd0);
        exp_key = 0;
        m_ext = 0;
        m_brk = 0;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        settling = 1'b0;
        send(8'h5A);
        check("enter_after_reset", bus.key, 16'd128);
        for (int n = 0; n < 60; n++)
            send_frame(POOL[$urandom_range(0, 23)], $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
